// File: rtl/csa_accumulator_if.sv
// csa_accumulator_if: operand stream in, resolved packet sum and count out.
interface csa_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save packet accumulator; one carry-propagate add per packet.
module csa_accumulator #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    csa_accumulator_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic take;
    assign take          = (state_q == ACCUM) && bus.in_valid;
    assign bus.in_ready  = state_q == ACCUM;
    assign bus.out_valid = state_q == OUTPUT;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = cnt_q;
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (take) begin
            s_d     = s_q ^ c_q ^ bus.in_data;
            c_d     = ((s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data)) << 1;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
            state_d = bus.in_last ? RESOLVE : ACCUM;
        end
        if (state_q == RESOLVE) begin
            sum_d   = s_q + c_q;
            state_d = OUTPUT;
        end
        if (state_q == OUTPUT && bus.out_ready) begin
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: two instances (8-bit and 2-bit counters) fed identical packets, checked against a plain-arithmetic model.
module tb_csa_accumulator;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    int vectors = 0, miscompares = 0;
    logic [31:0] pkt_q[$];
    always #5 clk = ~clk;
    csa_accumulator_if #(.WIDTH(32), .CNT_W(8)) a ();
    csa_accumulator_if #(.WIDTH(32), .CNT_W(2)) b ();
    assign a.in_valid = in_valid;
    assign a.in_data = in_data;
    assign a.in_last = in_last;
    assign a.out_ready = out_ready;
    assign b.in_valid = in_valid;
    assign b.in_data = in_data;
    assign b.in_last = in_last;
    assign b.out_ready = out_ready;
    csa_accumulator #(.WIDTH(32), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    csa_accumulator #(.WIDTH(32), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            in_valid = 0;
            in_data = $urandom;
            in_last = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        in_valid = 1;
        in_data = d;
        in_last = l;
        check("in_ready_a accum", 32'(a.in_ready), 1);
        check("in_ready_b accum", 32'(b.in_ready), 1);
        check("out_valid_a accum", 32'(a.out_valid), 0);
        tick();
        in_valid = 0;
        in_last = 0;
        in_data = $urandom;
    endtask

    task automatic run_packet(input int hold, input bit gaps);
        logic [31:0] sum;
        int n;
        sum = 0;
        n = pkt_q.size();
        foreach (pkt_q[i]) sum += pkt_q[i];
        foreach (pkt_q[i]) send(pkt_q[i], i == n - 1, gaps);
        out_ready = 0;
        check("in_ready_a resolve", 32'(a.in_ready), 0);
        check("out_valid_a resolve", 32'(a.out_valid), 0);
        check("out_valid_b resolve", 32'(b.out_valid), 0);
        tick();
        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            check("out_valid_a", 32'(a.out_valid), 1);
            check("out_valid_b", 32'(b.out_valid), 1);
            check("in_ready_a output", 32'(a.in_ready), 0);
            check("out_sum_a", a.out_sum, sum);
            check("out_sum_b", b.out_sum, sum);
            check("out_count_a", 32'(a.out_count), n > 255 ? 255 : n);
            check("out_count_b", 32'(b.out_count), n > 3 ? 3 : n);
            in_valid = 1'($urandom);
            in_data = $urandom;
            in_last = 1'($urandom);
            tick();
        end
        out_ready = 0;
        in_valid = 0;
        in_last = 0;
        check("out_valid_a after", 32'(a.out_valid), 0);
        check("in_ready_a after", 32'(a.in_ready), 1);
        check("out_count_a cleared", 32'(a.out_count), 0);
        pkt_q.delete();
    endtask

    initial begin
        rst = 1;
        tick();
        tick();
        rst = 0;
        check("rst out_valid", 32'(a.out_valid), 0);
        check("rst in_ready", 32'(a.in_ready), 1);
        check("rst out_sum", a.out_sum, 0);
        check("rst out_count", 32'(a.out_count), 0);
        pkt_q = '{32'd13, 32'd8};
        run_packet(0, 0);
        pkt_q = '{32'hFFFF_FFFF, 32'd1};
        run_packet(0, 0);
        pkt_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        run_packet(0, 0);
        pkt_q = '{32'd7};
        run_packet(5, 0);
        pkt_q = '{32'd2, 32'd2};
        run_packet(0, 0);
        send(32'd5, 0, 0);
        send(32'd6, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        check("midrst in_ready", 32'(a.in_ready), 1);
        check("midrst out_count", 32'(a.out_count), 0);
        pkt_q = '{32'd3};
        run_packet(0, 0);
        pkt_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        run_packet(0, 0);
        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pkt_q.push_back($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
            run_packet($urandom_range(0, 3), 1);
        end
        for (int i = 0; i < 300; i++) pkt_q.push_back($urandom);
        run_packet(1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
